// File: rtl/pll_rst_seq_if.sv
// Signals between the PLL lock reset sequencer and the PLL wrapper / reset consumers.
// The master side is the sequencer itself.
interface pll_rst_seq_if;
  logic       pll_lock;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       dsp_rst_n;
  logic       ready;
  logic [7:0] lock_loss_cnt;

  modport master (
    input  pll_lock,
    output pll_rst, sys_rst_n, dsp_rst_n, ready, lock_loss_cnt
  );

  modport slave (
    output pll_lock,
    input  pll_rst, sys_rst_n, dsp_rst_n, ready, lock_loss_cnt
  );
endinterface

// File: rtl/pll_rst_seq.sv
// Lock-qualified reset sequencer on the free-running reference clock.
// It resets the PLL until lock is stable, then releases the system resets and then the DSP resets.
module pll_rst_seq #(
  parameter int LOCK_FILTER    = 16,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int PLL_RST_CYCLES = 8,
  parameter int SYS_DELAY      = 64,
  parameter int DSP_DELAY      = 64
) (
  input logic          clk,
  input logic          rst_n,
  pll_rst_seq_if.master bus
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_P = max2(max2(max2(LOCK_FILTER, TIMEOUT_CYCLES),
                                   max2(PLL_RST_CYCLES, SYS_DELAY)), DSP_DELAY);
  localparam int CW = $clog2(MAX_P + 1);
  localparam int FW = $clog2(LOCK_FILTER + 1);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_SYS_HOLD,
    S_DSP_HOLD,
    S_RUN
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [FW-1:0] filt;
  logic          sync1, lock_s;
  logic          armed, run_seen, loss;
  logic          pll_rst_q, sys_rst_n_q, dsp_rst_n_q, ready_q;
  logic [7:0]    loss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= bus.pll_lock;
      lock_s <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= '0;
    end else if (!lock_s) begin
      filt <= '0;
    end else if (filt != FW'(LOCK_FILTER)) begin
      filt <= filt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    loss       = 1'b0;
    case (state)
      S_PLL_RST: begin
        if (armed && cnt == CW'(PLL_RST_CYCLES - 1)) state_next = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (filt == FW'(LOCK_FILTER)) state_next = S_SYS_HOLD;
        else if (cnt == CW'(TIMEOUT_CYCLES - 1)) state_next = S_PLL_RST;
      end
      S_SYS_HOLD: begin
        if (!lock_s) begin
          state_next = S_PLL_RST;
          loss       = run_seen;
        end else if (cnt == CW'(SYS_DELAY - 1)) begin
          state_next = S_DSP_HOLD;
        end
      end
      S_DSP_HOLD: begin
        if (!lock_s) begin
          state_next = S_PLL_RST;
          loss       = run_seen;
        end else if (cnt == CW'(DSP_DELAY - 1)) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_next = S_PLL_RST;
          loss       = 1'b1;
        end
      end
      default: state_next = S_PLL_RST;
    endcase
  end

  // The first edge after reset release acts as the PLL_RST entry edge, so the
  // pulse after reset is as wide as every later pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_PLL_RST;
      cnt      <= '0;
      armed    <= 1'b0;
      run_seen <= 1'b0;
    end else begin
      state <= state_next;
      armed <= 1'b1;
      if (!armed || state_next != state) cnt <= '0;
      else                               cnt <= cnt + 1'b1;
      if (state_next == S_RUN) run_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      dsp_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      pll_rst_q   <= (state_next == S_PLL_RST);
      sys_rst_n_q <= (state_next == S_DSP_HOLD) || (state_next == S_RUN);
      dsp_rst_n_q <= (state_next == S_RUN);
      ready_q     <= (state_next == S_RUN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt_q <= 8'd0;
    end else if (loss && loss_cnt_q != 8'hFF) begin
      loss_cnt_q <= loss_cnt_q + 8'd1;
    end
  end

  assign bus.pll_rst       = pll_rst_q;
  assign bus.sys_rst_n     = sys_rst_n_q;
  assign bus.dsp_rst_n     = dsp_rst_n_q;
  assign bus.ready         = ready_q;
  assign bus.lock_loss_cnt = loss_cnt_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Scoreboard bench for pll_rst_seq: expected output transitions are queued with the edge
// they must occur on, and a monitor matches every observed output change against them.
module tb_pll_rst_seq;

  logic clk;
  logic rst_n;
  int   cyc;
  int   t0;
  int   checks;
  int   failures;

  typedef struct {
    int          cyc;
    logic [11:0] val;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  logic [11:0] last;

  pll_rst_seq_if pif ();

  pll_rst_seq #(
    .LOCK_FILTER   (4),
    .TIMEOUT_CYCLES(32),
    .PLL_RST_CYCLES(8),
    .SYS_DELAY     (5),
    .DSP_DELAY     (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  function automatic logic [11:0] mk_vec(input logic pr, input logic sr, input logic dr,
                                         input logic rdy, input int n);
    logic [7:0] c;
    c = (n > 255) ? 8'hFF : n[7:0];
    return {pr, sr, dr, rdy, c};
  endfunction

  task automatic push_exp(input int k, input logic [11:0] v, input string nm);
    exp_t e;
    e.cyc  = t0 + k;
    e.val  = v;
    e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic checkOutput(input logic [11:0] cur);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $display("[TB] FAIL unexpected_change actual=%h at cycle %0d required=no change", cur, cyc);
    end else begin
      e = sbq.pop_front();
      if (e.val !== cur || e.cyc != cyc) begin
        failures++;
        $display("[TB] FAIL %s actual=%h at cycle %0d required=%h at cycle %0d",
                 e.name, cur, cyc, e.val, e.cyc);
      end
    end
  endtask

  // Outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [11:0] cur;
    cur = {pif.pll_rst, pif.sys_rst_n, pif.dsp_rst_n, pif.ready, pif.lock_loss_cnt};
    if (cur !== last) begin
      checkOutput(cur);
      last = cur;
    end
  end

  task automatic wait_until_edge(input int k);
    while (cyc < t0 + k - 1) @(negedge clk);
  endtask

  // The new lock value is first sampled by edge k.
  task automatic applyStimulus(input int k, input logic lock_val);
    wait_until_edge(k);
    pif.pll_lock = lock_val;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    t0    = cyc + 1;
  endtask

  task automatic apply_reset(input int k, input string nm);
    exp_t e;
    wait_until_edge(k);
    @(posedge clk);
    #2;
    e.cyc  = cyc;
    e.val  = mk_vec(1'b1, 1'b0, 1'b0, 1'b0, 0);
    e.name = nm;
    sbq.push_back(e);
    rst_n        = 1'b0;
    pif.pll_lock = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic loss_cycle(input int d, input int n, input bit full);
    push_exp(d + 2,  mk_vec(1'b1, 1'b0, 1'b0, 1'b0, n), "loss_resets_assert");
    push_exp(d + 10, mk_vec(1'b0, 1'b0, 1'b0, 1'b0, n), "loss_pll_rst_fall");
    push_exp(d + 16, mk_vec(1'b0, 1'b1, 1'b0, 1'b0, n), "loss_sys_release");
    if (full) push_exp(d + 19, mk_vec(1'b0, 1'b1, 1'b1, 1'b1, n), "loss_dsp_release");
    applyStimulus(d, 1'b0);
    applyStimulus(d + 2, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d;
    checks       = 0;
    failures     = 0;
    last         = 12'h000;
    t0           = 0;
    rst_n        = 1'b1;
    pif.pll_lock = 1'b0;
    begin
      exp_t e;
      e.cyc  = 1;
      e.val  = mk_vec(1'b1, 1'b0, 1'b0, 1'b0, 0);
      e.name = "reset_values";
      sbq.push_back(e);
    end
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Clean start, then a two-cycle lock loss from RUN.
    release_reset();
    push_exp(8,  mk_vec(1'b0, 1'b0, 1'b0, 1'b0, 0), "clean_pll_rst_fall");
    push_exp(31, mk_vec(1'b0, 1'b1, 1'b0, 1'b0, 0), "clean_sys_release");
    push_exp(34, mk_vec(1'b0, 1'b1, 1'b1, 1'b1, 0), "clean_dsp_release");
    applyStimulus(20, 1'b1);
    loss_cycle(50, 1, 1'b1);

    // Counter saturation, then an asynchronous reset while in DSP_HOLD.
    d = 71;
    for (int i = 2; i <= 300; i++) begin
      loss_cycle(d, i, 1'b1);
      d += 21;
    end
    loss_cycle(d, 301, 1'b0);
    apply_reset(d + 17, "async_reset_in_dsp_hold");

    // Lock glitch in WAIT_LOCK restarts the filter.
    release_reset();
    push_exp(8,  mk_vec(1'b0, 1'b0, 1'b0, 1'b0, 0), "glitch_pll_rst_fall");
    push_exp(27, mk_vec(1'b0, 1'b1, 1'b0, 1'b0, 0), "glitch_sys_release");
    push_exp(30, mk_vec(1'b0, 1'b1, 1'b1, 1'b1, 0), "glitch_dsp_release");
    applyStimulus(12, 1'b1);
    applyStimulus(15, 1'b0);
    applyStimulus(16, 1'b1);
    apply_reset(35, "reset_from_run");

    // No lock: periodic PLL reset pulses.
    release_reset();
    push_exp(8,  mk_vec(1'b0, 1'b0, 1'b0, 1'b0, 0), "nolock_fall_1");
    push_exp(40, mk_vec(1'b1, 1'b0, 1'b0, 1'b0, 0), "nolock_timeout_1");
    push_exp(48, mk_vec(1'b0, 1'b0, 1'b0, 1'b0, 0), "nolock_fall_2");
    push_exp(80, mk_vec(1'b1, 1'b0, 1'b0, 1'b0, 0), "nolock_timeout_2");
    push_exp(88, mk_vec(1'b0, 1'b0, 1'b0, 1'b0, 0), "nolock_fall_3");
    apply_reset(92, "reset_from_wait_lock");

    // Filter completes on the same edge the timeout expires: lock wins.
    release_reset();
    push_exp(8,  mk_vec(1'b0, 1'b0, 1'b0, 1'b0, 0), "simul_pll_rst_fall");
    push_exp(45, mk_vec(1'b0, 1'b1, 1'b0, 1'b0, 0), "simul_sys_release");
    push_exp(48, mk_vec(1'b0, 1'b1, 1'b1, 1'b1, 0), "simul_dsp_release");
    applyStimulus(34, 1'b1);
    wait_until_edge(60);

    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      failures++;
      $display("[TB] FAIL %s actual=no change required=%h at cycle %0d", e.name, e.val, e.cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
